// File: rtl/fc_score_streamer_if.sv
// Handshake/bus bundle between upstream producer, the score streamer and the
// argmax comparator. The streamer takes the slave view; the producer side
// (or a bench) takes the master view.
interface fc_score_if #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 16,
  parameter int OUT_W       = 12,
  parameter int IDX_W       = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CLASSES*ACC_W-1:0] in_scores;
  logic                         score_valid;
  logic [OUT_W-1:0]             score_data;
  logic                         dec_valid;
  logic [IDX_W-1:0]             dec_idx;
  logic                         result_valid;
  logic [IDX_W-1:0]             result_idx;
  logic                         frame_sat;
  logic                         timeout_err;

  modport master (
    output in_valid, in_scores, dec_valid, dec_idx,
    input  in_ready, score_valid, score_data, result_valid, result_idx,
           frame_sat, timeout_err
  );

  modport slave (
    input  in_valid, in_scores, dec_valid, dec_idx,
    output in_ready, score_valid, score_data, result_valid, result_idx,
           frame_sat, timeout_err
  );
endinterface

// File: rtl/fc_score_streamer.sv
// Transmit side of the FC-score stream: captures one saturated score vector,
// streams it one class per cycle to the argmax comparator, then waits for the
// comparator's decision (guarded by a timeout) and hands it back upstream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | in_ready high, waiting for a frame
// S_STREAM   | emitting buffered scores, one beat per cycle, class order
// S_WAIT_DEC | burst done, waiting for dec_valid or timeout expiry
module fc_score_streamer #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 16,
  parameter int OUT_W       = 12,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT     = 64
) (
  input logic     clk,
  input logic     rst_n,
  fc_score_if.slave bus
);

  localparam int BEAT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT);

  // Symmetric clip range: the most-negative code is reserved downstream as
  // the comparator's empty-slot marker, so it must never appear on the stream.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_DEC = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [OUT_W-1:0]  r_buf [NUM_CLASSES];
  logic [BEAT_W-1:0] r_beat;
  logic [TO_W-1:0]   r_tmo;

  logic              r_in_ready;
  logic              r_score_valid;
  logic [OUT_W-1:0]  r_score_data;
  logic              r_result_valid;
  logic [IDX_W-1:0]  r_result_idx;
  logic              r_frame_sat;
  logic              r_timeout_err;

  logic signed [ACC_W-1:0] w_acc [NUM_CLASSES];
  logic [OUT_W-1:0]        w_sat [NUM_CLASSES];
  logic                    w_sat_any;
  logic                    w_accept;
  logic                    w_take_dec;
  logic                    w_expire;
  logic                    w_last_beat;

  // Per-class saturation of the incoming accumulator vector.
  always_comb begin
    w_sat_any = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_acc[k] = bus.in_scores[k*ACC_W +: ACC_W];
      if (w_acc[k] > SAT_MAX) begin
        w_sat[k]  = SAT_MAX[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else if (w_acc[k] < SAT_MIN) begin
        w_sat[k]  = SAT_MIN[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else begin
        w_sat[k] = w_acc[k][OUT_W-1:0];
      end
    end
  end

  // Next-state decode and single-cycle event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_take_dec  = 1'b0;
    w_expire    = 1'b0;
    w_last_beat = (r_beat == BEAT_W'(NUM_CLASSES-1));
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_beat) w_state_nxt = S_WAIT_DEC;
      end
      S_WAIT_DEC: begin
        // A decision arriving on the expiry cycle still counts.
        if (bus.dec_valid) begin
          w_take_dec  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmo == '0) begin
          w_expire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Buffer, beat/timeout counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) r_buf[k] <= '0;
      r_beat         <= '0;
      r_tmo          <= '0;
      r_in_ready     <= 1'b1;
      r_score_valid  <= 1'b0;
      r_score_data   <= '0;
      r_result_valid <= 1'b0;
      r_result_idx   <= '0;
      r_frame_sat    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_in_ready     <= (w_state_nxt == S_IDLE);
      r_result_valid <= w_take_dec;
      r_timeout_err  <= w_expire;
      r_score_valid  <= (r_state == S_STREAM);

      if (w_accept) begin
        for (int k = 0; k < NUM_CLASSES; k++) r_buf[k] <= w_sat[k];
        r_frame_sat <= w_sat_any;
        r_beat      <= '0;
      end

      if (r_state == S_STREAM) begin
        r_score_data <= r_buf[r_beat];
        r_beat       <= r_beat + BEAT_W'(1);
      end

      // Timeout is a down-counter: loaded as the burst ends, expires at zero.
      if (r_state == S_STREAM && w_last_beat) begin
        r_tmo <= TO_W'(TIMEOUT-1);
      end else if (r_state == S_WAIT_DEC && r_tmo != '0) begin
        r_tmo <= r_tmo - TO_W'(1);
      end

      if (w_take_dec) r_result_idx <= bus.dec_idx;
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.score_valid  = r_score_valid;
  assign bus.score_data   = r_score_data;
  assign bus.result_valid = r_result_valid;
  assign bus.result_idx   = r_result_idx;
  assign bus.frame_sat    = r_frame_sat;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fc_score_streamer.sv
// Directed bench for fc_score_streamer: hand-computed score vectors, beat
// order, saturation, decision return, timeout and reset abort.
module tb_fc_score_streamer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fc_score_if #(.NUM_CLASSES(10), .ACC_W(16), .OUT_W(12), .IDX_W(4)) bus ();

  fc_score_streamer #(
    .NUM_CLASSES(10), .ACC_W(16), .OUT_W(12), .IDX_W(4), .TIMEOUT(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait is miscoded.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] pack_acc(input int v [10]);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'(v[k]);
    return r;
  endfunction

  function automatic logic [119:0] pack_exp(input int v [10]);
    logic [119:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*12 +: 12] = 12'(v[k]);
    return r;
  endfunction

  // Offer a frame, check the 10 beats; optionally inject stale dec/in_valid
  // at one beat, or pull reset at one beat and confirm the burst is dead.
  task automatic do_frame(input logic [159:0] vec, input logic [119:0] expv,
                          input logic exp_sat, input int stale_at, input int rst_at);
    int rv_cnt;
    int sv_cnt;
    int w;
    rv_cnt = 0;
    sv_cnt = 0;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_val("rdy_idle", 32'(bus.in_ready), 32'd1);
    bus.in_scores = vec;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("rdy_busy", 32'(bus.in_ready), 32'd0);
    check_val("sv_pre", 32'(bus.score_valid), 32'd0);
    check_val("frame_sat", 32'(bus.frame_sat), 32'(exp_sat));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_sv", 32'(bus.score_valid), 32'd0);
        check_val("rst_rdy", 32'(bus.in_ready), 32'd1);
        check_val("rst_fsat", 32'(bus.frame_sat), 32'd0);
        check_val("rst_rv", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
          @(negedge clk);
          if (bus.score_valid) sv_cnt++;
        end
        check_val("sv_after_rst", 32'(sv_cnt), 32'd0);
        return;
      end
      check_val($sformatf("beat%0d_sv", k), 32'(bus.score_valid), 32'd1);
      check_val($sformatf("beat%0d_d", k), 32'(bus.score_data), 32'(expv[k*12 +: 12]));
      check_val($sformatf("beat%0d_rdy", k), 32'(bus.in_ready), 32'd0);
      if (bus.result_valid) rv_cnt++;
      if (k == stale_at) begin
        bus.dec_valid = 1'b1;
        bus.dec_idx   = 4'd5;
        bus.in_valid  = 1'b1;
        bus.in_scores = ~vec;
      end else begin
        bus.dec_valid = 1'b0;
        bus.in_valid  = 1'b0;
      end
    end
    bus.dec_valid = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    if (bus.result_valid) rv_cnt++;
    check_val("sv_post", 32'(bus.score_valid), 32'd0);
    check_val("data_hold", 32'(bus.score_data), 32'(expv[9*12 +: 12]));
    check_val("no_stale_rv", 32'(rv_cnt), 32'd0);
  endtask

  // Wait, then return a decision and check the one-cycle result pulse.
  task automatic do_dec(input int delay, input logic [3:0] idx);
    int bad;
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.result_valid || bus.timeout_err) bad++;
    end
    check_val("wait_quiet", 32'(bad), 32'd0);
    bus.dec_valid = 1'b1;
    bus.dec_idx   = idx;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    check_val("rv_pulse", 32'(bus.result_valid), 32'd1);
    check_val("ridx", 32'(bus.result_idx), 32'(idx));
    check_val("terr_dec", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check_val("rv_end", 32'(bus.result_valid), 32'd0);
    check_val("terr_after", 32'(bus.timeout_err), 32'd0);
    check_val("rdy_back", 32'(bus.in_ready), 32'd1);
  endtask

  // Main sequence.
  initial begin
    int a_in [10];
    int a_ex [10];
    int b_in [10];
    int b_ex [10];
    int c_in [10];
    int c_ex [10];
    int d_in [10];
    int seen;
    int rv_seen;

    n_checks = 0;
    n_fail   = 0;
    a_in = '{0, 5, -3, 100, 7, -9, 2, 99, 1, -1};
    a_ex = '{0, 5, -3, 100, 7, -9, 2, 99, 1, -1};
    b_in = '{3000, -5000, 0, 0, 0, 0, 0, 0, 0, 0};
    b_ex = '{2047, -2047, 0, 0, 0, 0, 0, 0, 0, 0};
    c_in = '{2047, -2047, -2048, 2048, -2049, 32767, -32768, 0, 0, 0};
    c_ex = '{2047, -2047, -2047, 2047, -2047, 2047, -2047, 0, 0, 0};
    d_in = '{2047, -2047, 0, 0, 0, 0, 0, 0, 0, 0};

    bus.in_valid  = 1'b0;
    bus.in_scores = '0;
    bus.dec_valid = 1'b0;
    bus.dec_idx   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_rdy", 32'(bus.in_ready), 32'd1);
    check_val("reset_sv", 32'(bus.score_valid), 32'd0);
    check_val("reset_rv", 32'(bus.result_valid), 32'd0);
    check_val("reset_terr", 32'(bus.timeout_err), 32'd0);
    check_val("reset_fsat", 32'(bus.frame_sat), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stale decision while idle.
    bus.dec_valid = 1'b1;
    bus.dec_idx   = 4'd8;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    check_val("idle_stale_rv", 32'(bus.result_valid), 32'd0);
    check_val("idle_stale_idx", 32'(bus.result_idx), 32'd0);

    do_frame(pack_acc(a_in), pack_exp(a_ex), 1'b0, -1, -1);
    do_dec(6, 4'd3);

    do_frame(pack_acc(b_in), pack_exp(b_ex), 1'b1, -1, -1);
    do_dec(2, 4'd9);

    do_frame(pack_acc(c_in), pack_exp(c_ex), 1'b1, -1, -1);
    do_dec(0, 4'd1);

    // Exact limits pass through unclipped.
    do_frame(pack_acc(d_in), pack_exp(d_in), 1'b0, -1, -1);
    do_dec(1, 4'd2);

    // No decision: pulse lands 64 cycles after the last beat, i.e. 63
    // negedges after the first idle-beat sample where do_frame returns.
    do_frame(pack_acc(a_in), pack_exp(a_ex), 1'b0, -1, -1);
    seen = 0;
    rv_seen = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen++;
      if (bus.timeout_err) begin
        seen = i;
        break;
      end
    end
    check_val("tmo_at", 32'(seen), 32'd63);
    check_val("tmo_no_rv", 32'(rv_seen), 32'd0);
    check_val("tmo_rdy", 32'(bus.in_ready), 32'd1);
    check_val("tmo_ridx", 32'(bus.result_idx), 32'd2);
    @(negedge clk);
    check_val("tmo_pulse_end", 32'(bus.timeout_err), 32'd0);

    // Decision on the expiry cycle wins.
    do_frame(pack_acc(d_in), pack_exp(d_in), 1'b0, -1, -1);
    do_dec(62, 4'd6);

    // Stale dec_valid and in_valid mid-burst are ignored.
    do_frame(pack_acc(a_in), pack_exp(a_ex), 1'b0, 4, -1);
    do_dec(3, 4'd7);

    // Reset mid-burst, then a clean frame.
    do_frame(pack_acc(a_in), pack_exp(a_ex), 1'b0, -1, 5);
    do_frame(pack_acc(a_in), pack_exp(a_ex), 1'b0, -1, -1);
    do_dec(2, 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
